// File: rtl/addsub_pkg.sv
// addsub_pkg: opcode and flag types shared by the add/subtract pipeline
package addsub_pkg;
    typedef enum logic [1:0] {ADD = 2'd0, ADC = 2'd1, SUB = 2'd2, SBB = 2'd3} op_e;
    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;
endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational W-bit adder slice producing carry-out and a segment-zero flag
module addsub_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         zero
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign zero = ~|sum;
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented-carry pipelined add/subtract with Z/N/C/V flags and valid/ready handshake
// Define ADDSUB_PIPE_OVF_EN to compute v; otherwise v is tied low.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             z,
    output logic             n,
    output logic             v
);
    localparam int STAGES = WIDTH / SEG;
    if (WIDTH < 2 || WIDTH % SEG != 0) begin : g_chk
        $error("addsub_pipe: WIDTH must be >= 2 and a multiple of SEG");
    end
    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;
    flags_t           fl;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign bx = (op == SUB || op == SBB) ? ~b : b;
    assign c0 = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : cin;
    // Rank k holds the low k+1 sum segments plus the still-unconsumed operand segments above them.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG;
        localparam int RW = WIDTH - LO;
        logic [RW-1:0]     ai, bi;
        logic              ci, zi, vi, co, zo, vld, c, za;
        logic [SEG-1:0]    so;
        logic [LO+SEG-1:0] sn, s;
        if (k == 0) begin : src
            assign ai = a;
            assign bi = bx;
            assign ci = c0;
            assign zi = 1'b1;
            assign vi = in_valid;
            assign sn = so;
        end else begin : src
            assign ai = stg[k-1].opr.ra;
            assign bi = stg[k-1].opr.rb;
            assign ci = stg[k-1].c;
            assign zi = stg[k-1].za;
            assign vi = stg[k-1].vld;
            assign sn = {so, stg[k-1].s};
        end
        addsub_seg #(.W(SEG)) u_seg (
            .a    (ai[SEG-1:0]),
            .b    (bi[SEG-1:0]),
            .cin  (ci),
            .sum  (so),
            .cout (co),
            .zero (zo)
        );
        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
                c   <= 1'b0;
                za  <= 1'b0;
                s   <= '0;
            end else if (adv) begin
                vld <= vi;
                c   <= co;
                za  <= zi & zo;
                s   <= sn;
            end
        end
        if (k < STAGES - 1) begin : opr
            logic [RW-SEG-1:0] ra, rb;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                end else if (adv) begin
                    ra <= ai[RW-1:SEG];
                    rb <= bi[RW-1:SEG];
                end
            end
        end
    end
`ifdef ADDSUB_PIPE_OVF_EN
    logic vr;
    always_ff @(posedge clk) begin
        if (rst)
            vr <= 1'b0;
        else if (adv)
            vr <= (stg[STAGES-1].ai[SEG-1] == stg[STAGES-1].bi[SEG-1]) &&
                  (stg[STAGES-1].so[SEG-1] != stg[STAGES-1].ai[SEG-1]);
    end
    assign fl.v = vr;
`else
    assign fl.v = 1'b0;
`endif
    assign out_valid = stg[STAGES-1].vld;
    assign sum       = stg[STAGES-1].s;
    assign fl.c      = stg[STAGES-1].c;
    assign fl.z      = stg[STAGES-1].za;
    assign fl.n      = sum[WIDTH-1];
    assign cout      = fl.c;
    assign z         = fl.z;
    assign n         = fl.n;
    assign v         = fl.v;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of addsub_pipe (WIDTH=32, SEG=8, four-cycle latency)
module tb_addsub_pipe;
    import addsub_pkg::*;
    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, cin, cout, z, n, v;
    op_e         op;
    logic [31:0] a, b, sum;
    int          total = 0;
    int          bad = 0;
`ifdef ADDSUB_PIPE_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    addsub_pipe #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .z(z), .n(n), .v(v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One op through an otherwise idle pipe; flags expected as {c,z,n,v}.
    task automatic run(input string tag, input op_e o, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc, input logic [31:0] es, input logic [3:0] ef);
        op = o; a = ta; b = tb; cin = tc; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        chk({tag, ".early"}, {31'd0, out_valid}, 32'd0);
        cyc();
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".flags"}, {28'd0, cout, z, n, v}, {28'd0, ef});
        cyc();
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] e, held;
        logic [5:0]  rdy;
        int          got, last, seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = ADD; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum", sum, 32'd0);
        chk("rst.flags", {28'd0, cout, z, n, v}, 32'd0);
        chk("rst.ready", {31'd0, in_ready}, 32'd1);

        run("add", ADD, 32'hFF000F0F, 32'h00FFF0F0, 1'b0, 32'hFFFFFFFF, 4'b0010);
        run("sub1m3", SUB, 32'h00000001, 32'h00000003, 1'b0, 32'hFFFFFFFE, 4'b0010);
        run("sub5m5", SUB, 32'd5, 32'd5, 1'b0, 32'd0, 4'b1100);
        run("addovf", ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, {3'b001, OVF});
        run("adc", ADC, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 4'b1100);
        run("wrap", ADD, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 4'b1100);
        run("sbb", SBB, 32'd5, 32'd3, 1'b0, 32'd1, 4'b1000);
        run("addcin", ADD, 32'd2, 32'd3, 1'b1, 32'd5, 4'b0000);
        run("subovf", SUB, 32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, {3'b100, OVF});

        out_ready = 1'b0;
        rdy = '0;
        for (int i = 0; i < 6; i++) begin
            op = ADD; cin = 1'b0; in_valid = 1'b1;
            a = 32'h01000000 * (i + 1) + i; b = 32'h00FF00FF;
            rdy[i] = in_ready;
            if (in_ready) q.push_back(a + b);
            if (i == 4) held = sum;
            cyc();
        end
        chk("stall.ready", {26'd0, rdy}, 32'h0000000F);
        chk("stall.first", held, 32'h01FF00FF);
        chk("stall.hold", sum, held);
        chk("stall.valid", {31'd0, out_valid}, 32'd1);
        chk("stall.noready", {31'd0, in_ready}, 32'd0);

        in_valid = 1'b0; out_ready = 1'b1; got = 0; last = -1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                e = (q.size() != 0) ? q.pop_front() : 'x;
                chk("drain.sum", sum, e);
                got++;
                last = i;
            end
            cyc();
        end
        chk("drain.count", got, 32'd4);
        chk("drain.last", last, 32'd3);

        for (int i = 0; i < 3; i++) begin
            op = SUB; a = 32'd100 + i; b = i; cin = 1'b0; in_valid = 1'b1;
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.sum", sum, 32'd0);
        chk("flush.flags", {28'd0, cout, z, n, v}, 32'd0);
        chk("flush.ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (6) begin
            cyc();
            if (out_valid) seen++;
        end
        chk("flush.stale", seen, 32'd0);
        run("post", ADD, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
